password_verify: RTL
====================

PASSWORD_VERIFY -- requirements
Module: password_verify

Interface
REQ-001 SHALL have parameter MAX_TRY, default 3: consecutive wrong entries that trigger lockout (range 1..3).
REQ-002 SHALL have parameter OPEN_CYCLES, default 8: cycles unlock stays high after a correct entry.
REQ-003 SHALL have parameter LOCK_CYCLES, default 16: cycles of lockout after MAX_TRY failures.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 pw_6  input  6  code entered by the user.
REQ-007 enter  input  1  level from the user key; only its rising edge is a request.
REQ-008 npw  input  6  stored password, driven by the password-set block.
REQ-009 status  input  1  stored password valid; 0 means no password is set.
REQ-010 unlock  output  1  door open, registered.
REQ-011 err  output  1  one-cycle pulse on a wrong entry or on a request with status=0, registered.
REQ-012 alarm  output  1  lockout active, registered.
REQ-013 fail_cnt  output  2  consecutive wrong entries, registered.

Function
REQ-014 enter SHALL be registered into enter_q; a request is detected at an edge where enter=1 and enter_q=0.
REQ-015 The FSM SHALL have the states IDLE, CHECK, OPEN, FAIL and LOCKOUT.
REQ-016 In IDLE, a detected request with status=1 SHALL latch pw_6 into code_q and move to CHECK at that edge.
REQ-017 In IDLE, a detected request with status=0 SHALL pulse err for one cycle, leave the state as IDLE and leave fail_cnt unchanged.
REQ-018 CHECK SHALL last exactly one cycle and compare code_q with npw as sampled in that cycle.
REQ-019 On a match, CHECK SHALL go to OPEN, clear fail_cnt and set unlock.
REQ-020 On a mismatch, CHECK SHALL increment fail_cnt, then:
- go to LOCKOUT and set alarm if the new count equals MAX_TRY;
- otherwise go to FAIL and pulse err.
REQ-021 OPEN SHALL hold unlock=1 for exactly OPEN_CYCLES cycles, then return to IDLE with unlock=0.
REQ-022 FAIL SHALL last one cycle (err=1 during it), then return to IDLE.
REQ-023 LOCKOUT SHALL hold alarm=1 for exactly LOCK_CYCLES cycles, then return to IDLE with alarm=0 and fail_cnt=0.
REQ-024 Latency: with a request detected at edge k, the correct or incorrect result SHALL be visible on the outputs after edge k+1.
REQ-025 Requests detected outside IDLE SHALL be discarded, not queued.
REQ-026 A held enter level SHALL generate only one request; a new request requires enter to return to 0 first.
REQ-027 A change of npw or status during OPEN, FAIL or LOCKOUT SHALL NOT affect the current state or timer.
REQ-028 fail_cnt SHALL saturate at MAX_TRY and never wrap.
REQ-029 The dwell timers SHALL be wide enough for the parameter values and SHALL reload on each state entry.
REQ-030 At most one of unlock, err and alarm SHALL be high in any cycle.

Reset
REQ-031 While rst_n=0, the following SHALL hold, independent of clk:
- state=IDLE;
- unlock=0, err=0, alarm=0;
- fail_cnt=0;
- code_q=0, enter_q=0, timers=0.
REQ-032 An assertion of rst_n in any state, including mid-OPEN or mid-LOCKOUT, SHALL abort the operation immediately.
REQ-033 If enter is already 1 when rst_n is released, that level SHALL NOT count as a request until enter falls and rises again.

Verification
REQ-034 Correct entry: npw=6'h2A, status=1, pw_6=6'h2A, enter rises -> unlock=1 from edge k+1 for 8 cycles, err=0, fail_cnt=0.
REQ-035 Single wrong entry: pw_6=6'h15, one request -> err pulses for 1 cycle, fail_cnt=1; a following correct entry -> unlock, fail_cnt=0.
REQ-036 Lockout: three wrong entries -> the third sets alarm=1 for 16 cycles and fail_cnt=2'd3; requests during the lockout are ignored; afterwards fail_cnt=0.
REQ-037 No password set: status=0, enter rises -> err pulses for 1 cycle, fail_cnt=0, unlock never asserts.
REQ-038 Held enter: enter held high for 10 cycles with a wrong code -> exactly one err pulse and fail_cnt=1.
REQ-039 Reset mid-operation: rst_n driven low during OPEN cycle 3 -> unlock=0 immediately; after release, state=IDLE and fail_cnt=0.

Source files
------------

// File: rtl/password_verify.sv
// -----------------------------------------------------------------------------
// password_verify
//   Checks a 6-bit user code against the stored password on each rising edge
//   of the enter key. A correct code opens the door for OPEN_CYCLES cycles. A
//   wrong code pulses err and counts the failure. MAX_TRY consecutive failures
//   raise alarm for LOCK_CYCLES cycles. A request while no password is stored
//   pulses err and changes nothing else. Requests that arrive outside IDLE are
//   dropped.
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   pw_6      in   [5:0] code entered by the user
//   enter     in   user key level; a request is its rising edge
//   npw       in   [5:0] stored password
//   status    in   stored password valid
//   unlock    out  door open (registered)
//   err       out  one-cycle error pulse (registered)
//   alarm     out  lockout active (registered)
//   fail_cnt  out  [1:0] consecutive wrong entries (registered)
// -----------------------------------------------------------------------------
module password_verify #(
   parameter int MAX_TRY     = 3,
   parameter int OPEN_CYCLES = 8,
   parameter int LOCK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] pw_6,
   input  logic       enter,
   input  logic [5:0] npw,
   input  logic       status,
   output logic       unlock,
   output logic       err,
   output logic       alarm,
   output logic [1:0] fail_cnt
);

   // The timer counts down from N-1 to 0, so it only needs to hold max-1.
   localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
   localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
   localparam logic [1:0]    MAX_CNT   = 2'(MAX_TRY);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      OPEN,
      FAIL,
      LOCKOUT
   } state_t;

   state_t        state, state_d;
   logic          enter_q;
   logic          armed, armed_d;
   logic [5:0]    code_q, code_d;
   logic [TW-1:0] timer, timer_d;
   logic          unlock_d, err_d, alarm_d;
   logic [1:0]    cnt_d, cnt_inc;
   logic          req;

   // armed stays low after reset until enter has been seen low once, so a key
   // already held down across reset release does not count as a press.
   assign armed_d = armed | ~enter;
   assign req     = enter & ~enter_q & armed;

   // Saturating increment; lockout normally clears the count before it could
   // reach MAX_CNT here, the clamp only keeps it from ever wrapping.
   assign cnt_inc = (fail_cnt >= MAX_CNT) ? MAX_CNT : fail_cnt + 2'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         enter_q  <= 1'b0;
         armed    <= 1'b0;
         code_q   <= '0;
         timer    <= '0;
         unlock   <= 1'b0;
         err      <= 1'b0;
         alarm    <= 1'b0;
         fail_cnt <= 2'd0;
      end else begin
         state    <= state_d;
         enter_q  <= enter;
         armed    <= armed_d;
         code_q   <= code_d;
         timer    <= timer_d;
         unlock   <= unlock_d;
         err      <= err_d;
         alarm    <= alarm_d;
         fail_cnt <= cnt_d;
      end
   end

   // Next state and next registered outputs. The pulse-type outputs default
   // low so each state only names the outputs it holds high.
   always_comb begin
      state_d  = state;
      code_d   = code_q;
      timer_d  = timer;
      cnt_d    = fail_cnt;
      unlock_d = 1'b0;
      err_d    = 1'b0;
      alarm_d  = 1'b0;

      case (state)
         IDLE: begin
            if (req) begin
               if (status) begin
                  code_d  = pw_6;
                  state_d = CHECK;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         CHECK: begin
            if (code_q == npw) begin
               state_d  = OPEN;
               unlock_d = 1'b1;
               cnt_d    = 2'd0;
               timer_d  = OPEN_LOAD;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == MAX_CNT) begin
                  state_d = LOCKOUT;
                  alarm_d = 1'b1;
                  timer_d = LOCK_LOAD;
               end else begin
                  state_d = FAIL;
                  err_d   = 1'b1;
               end
            end
         end

         OPEN: begin
            if (timer == '0) begin
               state_d = IDLE;
            end else begin
               timer_d  = timer - 1'b1;
               unlock_d = 1'b1;
            end
         end

         FAIL: begin
            state_d = IDLE;
         end

         LOCKOUT: begin
            if (timer == '0) begin
               state_d = IDLE;
               cnt_d   = 2'd0;
            end else begin
               timer_d = timer - 1'b1;
               alarm_d = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
